uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter PACK_SIZE, default 8: byte width, matching the uart_top PACK_SIZE.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000: watchdog limit in clk cycles; used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have ports:
clk  in  1  system clock; one clock domain; all logic on posedge.
rst  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 offers a byte.
req0_data  in  PACK_SIZE  requester 0 byte.
req0_last  in  1  byte ends requester 0 frame.
req0_ready  out  1  requester 0 byte accepted this cycle.
req1_valid / req1_data / req1_last / req1_ready  same as requester 0, for requester 1.
tx_byte_valid  out  1  one-cycle launch strobe to the uart_top transmitter.
tx_byte_data  out  PACK_SIZE  byte to the uart_top transmitter.
tx_active  in  1  transmitter busy.
tx_done  in  1  transmitter completion strobe.
grant  out  2  one-hot frame owner; 2'b00 when no owner.
busy  out  1  byte in flight or frame lock held.
timeout_err  out  1  one-cycle watchdog strobe.

Function
REQ-004 SHALL implement states IDLE, LAUNCH, WAIT_DONE.
REQ-005 In IDLE with no lock, SHALL pick among asserted reqN_valid; if both are asserted, SHALL pick the requester not served last (round-robin).
REQ-006 In IDLE with a lock held by requester k, SHALL consider only requester k; the other requester waits.
REQ-007 reqN_ready SHALL be combinational: high only in IDLE, for the selected requester, while reqN_valid is high.
REQ-008 On acceptance, SHALL register reqN_data into tx_byte_data, set grant to the one-hot of N, and go to LAUNCH.
REQ-009 In LAUNCH, SHALL drive tx_byte_valid high for exactly that one cycle, then go to WAIT_DONE.
REQ-010 tx_byte_valid SHALL be low in all other states.
REQ-011 tx_byte_data SHALL hold its value until the next acceptance.
REQ-012 In WAIT_DONE, tx_done SHALL return the FSM to IDLE next cycle.
REQ-013 tx_done in IDLE or LAUNCH SHALL be ignored.
REQ-014 tx_active SHALL be used only for the watchdog; it does not affect state transitions.
REQ-015 Accepted byte with last=0 SHALL set or keep the lock on N.
REQ-016 Accepted byte with last=1 SHALL clear the lock when that byte's WAIT_DONE exits, mark N as last served, and clear grant to 2'b00 at that point.
REQ-017 grant SHALL remain set between bytes of a locked frame.
REQ-018 busy SHALL equal (state != IDLE) OR lock.
REQ-019 Minimum acceptance-to-next-acceptance spacing SHALL be 3 cycles (tx_done in the first WAIT_DONE cycle).
REQ-020 A requester deasserting valid mid-frame SHALL keep the lock indefinitely; no implicit frame abort.

Reset
REQ-021 When rst is high, the block SHALL set: state IDLE; tx_byte_valid 0; tx_byte_data 0; grant 2'b00; lock cleared; last-served = requester 1, so requester 0 wins the first tie; watchdog counter 0; timeout_err 0.
REQ-022 reqN_ready SHALL be 0 while rst is high.
REQ-023 rst mid-frame or in LAUNCH/WAIT_DONE SHALL abandon the byte and frame with no further tx_byte_valid.

Configuration
REQ-024 Macro UART_ARB_TIMEOUT_EN, when defined: a counter SHALL run in WAIT_DONE and clear on entry to WAIT_DONE.
REQ-025 With UART_ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYC-1 without tx_done, the block SHALL pulse timeout_err for one cycle, return to IDLE, clear the lock, clear grant, and mark the owner as last served.
REQ-026 With UART_ARB_TIMEOUT_EN defined, tx_done in the same cycle as expiry SHALL win: normal completion, no timeout_err.
REQ-027 When UART_ARB_TIMEOUT_EN is undefined, timeout_err SHALL be tied 0, no counter SHALL exist, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-028 Single byte: req0 valid, data 8'hA5, last=1. Required: req0_ready in cycle T, tx_byte_valid with 8'hA5 at T+1, grant=01. Then tx_done at T+10 gives IDLE and grant=00 at T+11.
REQ-029 Tie: req0 8'h11 and req1 8'h22, both last=1, both held valid from reset. Required launch order 11, 22, 11, 22.
REQ-030 Lock: req0 sends 3 bytes 8'h01, 8'h02, 8'h03 (last on 03) while req1 is valid with 8'h44. Required: 01, 02, 03 launched before 44; grant stays 01 for the whole frame.
REQ-031 Reset mid-frame: rst asserted in WAIT_DONE of req1 byte 1 of 2. Required: no tx_byte_valid in the 5 cycles after, grant=00, busy=0, and next tie goes to req0.
REQ-032 Timeout (macro defined, TIMEOUT_CYC=16): launch a byte and withhold tx_done. Required: timeout_err pulses exactly 16 cycles after WAIT_DONE entry, then IDLE.
REQ-033 Done/expiry coincidence (macro defined, TIMEOUT_CYC=16): tx_done in the expiry cycle. Required: no timeout_err.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Two-requester byte arbiter in front of a UART transmitter; frames lock the owner until the last byte completes.
// Latency: accept -> tx_byte_valid 1 cycle; next accept no sooner than 3 cycles after the previous one.
// Backpressure: reqN_ready only in IDLE for the chosen requester; optional watchdog via UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
   parameter int PACK_SIZE   = 8,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [PACK_SIZE-1:0] req0_data,
   input  logic                 req0_last,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [PACK_SIZE-1:0] req1_data,
   input  logic                 req1_last,
   output logic                 req1_ready,
   output logic                 tx_byte_valid,
   output logic [PACK_SIZE-1:0] tx_byte_data,
   input  logic                 tx_active,
   input  logic                 tx_done,
   output logic [1:0]           grant,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LAUNCH    = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;

   logic [1:0]           state;
   logic                 lock;
   logic                 lock_owner;
   logic                 last_served;
   logic                 cur_owner;
   logic                 cur_last;
   logic                 sel_vld;
   logic                 sel_idx;
   logic                 sel_last;
   logic [PACK_SIZE-1:0] sel_data;
   logic                 accept;
   logic                 expire;

   // The transmitter's busy flag is informational only; the FSM keys off tx_done.
   logic unused_tx_active;
   assign unused_tx_active = tx_active;

   always_comb begin
      sel_vld = 1'b0;
      sel_idx = 1'b0;
      if (lock) begin
         sel_idx = lock_owner;
         sel_vld = lock_owner ? req1_valid : req0_valid;
      end else if (req0_valid && req1_valid) begin
         sel_vld = 1'b1;
         sel_idx = ~last_served;
      end else if (req0_valid) begin
         sel_vld = 1'b1;
      end else if (req1_valid) begin
         sel_vld = 1'b1;
         sel_idx = 1'b1;
      end
      sel_last = sel_idx ? req1_last : req0_last;
      sel_data = sel_idx ? req1_data : req0_data;
   end

   assign accept        = !rst && (state == IDLE) && sel_vld;
   assign req0_ready    = accept && !sel_idx;
   assign req1_ready    = accept && sel_idx;
   assign tx_byte_valid = (state == LAUNCH);
   assign busy          = (state != IDLE) || lock;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wd_cnt;

   // A tx_done landing on the expiry cycle is a normal completion.
   assign expire = (state == WAIT_DONE) && !tx_done && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= expire;
         if (state == LAUNCH) begin
            wd_cnt <= '0;
         end else if (state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;

   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tx_byte_data <= '0;
         grant        <= 2'b00;
         lock         <= 1'b0;
         lock_owner   <= 1'b0;
         last_served  <= 1'b1;
         cur_owner    <= 1'b0;
         cur_last     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  tx_byte_data <= sel_data;
                  grant        <= {sel_idx, ~sel_idx};
                  cur_owner    <= sel_idx;
                  cur_last     <= sel_last;
                  if (!sel_last) begin
                     lock       <= 1'b1;
                     lock_owner <= sel_idx;
                  end
                  state <= LAUNCH;
               end
            end
            LAUNCH: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (tx_done || expire) begin
                  state <= IDLE;
                  // Frame ends on its last byte, or is dropped when the watchdog fires.
                  if (cur_last || expire) begin
                     lock        <= 1'b0;
                     grant       <= 2'b00;
                     last_served <= cur_owner;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
